rifl_axis_downsizer: RTL and testbench



---
 rtl/rifl_axis_pkg.sv | 42 ++++
 rtl/rifl_seg_prio_enc.sv | 33 +++
 rtl/rifl_axis_downsizer.sv | 143 ++++++++++++++
 tb/tb_rifl_axis_downsizer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rifl_axis_pkg.sv
// Shared types and helpers for the RIFL AXI-Stream width down-converter.
// The null-slice skipping option is selected by RIFL_DWC_SKIP_NULL_EN.
package rifl_axis_pkg;

   localparam int unsigned MAX_KEEP    = 512;
   localparam int unsigned MAX_RATIO   = 64;
   localparam int unsigned MAX_KEEP_W  = $clog2(MAX_KEEP);
   localparam int unsigned MAX_RATIO_W = $clog2(MAX_RATIO);

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } dwc_state_e;

   function automatic int unsigned dwc_ratio(input int unsigned s_dwidth,
                                             input int unsigned m_dwidth);
      return (m_dwidth == 0) ? 0 : s_dwidth / m_dwidth;
   endfunction

   function automatic int unsigned dwc_idx_width(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic bit dwc_ratio_ok(input int unsigned ratio);
      return (ratio >= 2) && (ratio <= MAX_RATIO) && ((ratio & (ratio - 1)) == 0);
   endfunction

   // Bit k of the result is set when slice k has at least one keep bit set.
   function automatic logic [MAX_RATIO-1:0] slice_nonnull(input logic [MAX_KEEP-1:0] keep,
                                                          input int unsigned        ratio,
                                                          input int unsigned        slice_bytes);
      logic [MAX_RATIO-1:0] nn;
      nn = '0;
      for (int unsigned i = 0; i < MAX_KEEP; i++) begin
         if ((i < ratio * slice_bytes) && keep[MAX_KEEP_W'(i)]) begin
            nn[MAX_RATIO_W'(i / slice_bytes)] = 1'b1;
         end
      end
      return nn;
   endfunction

endpackage

// File: rtl/rifl_seg_prio_enc.sv
// Slice priority encoder: first set slice at or after start, highest set
// slice, and an all-clear flag.
module rifl_seg_prio_enc
   import rifl_axis_pkg::*;
#(
   parameter int unsigned RATIO = 4,
   localparam int unsigned IW   = dwc_idx_width(RATIO)
) (
   input  logic [RATIO-1:0] vec,
   input  logic [IW-1:0]    start,
   output logic [IW-1:0]    next_idx,
   output logic [IW-1:0]    high_idx,
   output logic             none
);

   always_comb begin
      logic found;
      found    = 1'b0;
      next_idx = start;
      high_idx = '0;
      none     = ~|vec;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (vec[IW'(i)]) begin
            high_idx = IW'(i);
            if (!found && (IW'(i) >= start)) begin
               next_idx = IW'(i);
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rifl_axis_downsizer.sv
// AXI-Stream width down-converter: one wide word in, RATIO narrow beats out,
// LSB slice first. Define RIFL_DWC_SKIP_NULL_EN to skip null slices in every word.
module rifl_axis_downsizer
   import rifl_axis_pkg::*;
#(
   parameter int unsigned S_DWIDTH = 512,
   parameter int unsigned M_DWIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [S_DWIDTH-1:0]   s_axis_tdata,
   input  logic [S_DWIDTH/8-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [M_DWIDTH-1:0]   m_axis_tdata,
   output logic [M_DWIDTH/8-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   localparam int unsigned RATIO  = dwc_ratio(S_DWIDTH, M_DWIDTH);
   localparam int unsigned IW     = dwc_idx_width(RATIO);
   localparam int unsigned S_KEEP = S_DWIDTH / 8;
   localparam int unsigned M_KEEP = M_DWIDTH / 8;
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   generate
      if ((S_DWIDTH % 8 != 0) || (M_DWIDTH % 8 != 0) || (M_DWIDTH == 0) ||
          (RATIO * M_DWIDTH != S_DWIDTH) || !dwc_ratio_ok(RATIO) || (S_KEEP > MAX_KEEP)) begin : g_bad_cfg
         $error("rifl_axis_downsizer: widths must be byte multiples with a power-of-two ratio >= 2");
      end
   endgenerate

   dwc_state_e            state_q, state_d;
   logic [S_DWIDTH-1:0]   data_q, data_d;
   logic [S_KEEP-1:0]     keep_q, keep_d;
   logic                  last_q, last_d;
   logic [IW-1:0]         idx_q, idx_d;

   logic [RATIO-1:0]      hold_nn;
   logic [IW-1:0]         hold_next, hold_high;
   logic                  hold_none;
   logic [IW-1:0]         fin, adv_idx, load_idx;
   logic                  load_valid;
   logic                  valid_q, at_fin, accept;

   assign hold_nn = RATIO'(slice_nonnull(MAX_KEEP'(keep_q), RATIO, M_KEEP));

   rifl_seg_prio_enc #(.RATIO(RATIO)) u_hold_enc (
      .vec      (hold_nn),
      .start    (IW'(idx_q + 1'b1)),
      .next_idx (hold_next),
      .high_idx (hold_high),
      .none     (hold_none)
   );

`ifdef RIFL_DWC_SKIP_NULL_EN
   logic [RATIO-1:0] in_nn;
   logic [IW-1:0]    in_first, in_high;
   logic             in_none;
   logic             unused_enc_bits;

   assign in_nn = RATIO'(slice_nonnull(MAX_KEEP'(s_axis_tkeep), RATIO, M_KEEP));

   rifl_seg_prio_enc #(.RATIO(RATIO)) u_in_enc (
      .vec      (in_nn),
      .start    ('0),
      .next_idx (in_first),
      .high_idx (in_high),
      .none     (in_none)
   );

   // Highest set index is 0 when the keep is empty, which gives the single keep-0 beat.
   assign fin        = hold_high;
   assign adv_idx    = hold_next;
   assign load_idx   = in_none ? '0 : in_first;
   assign load_valid = s_axis_tlast | ~in_none;
   assign unused_enc_bits = ^{in_high, hold_none};
`else
   logic unused_enc_bits;

   assign fin        = last_q ? hold_high : LAST_IDX;
   assign adv_idx    = IW'(idx_q + 1'b1);
   assign load_idx   = '0;
   assign load_valid = 1'b1;
   assign unused_enc_bits = ^{hold_next, hold_none};
`endif

   assign valid_q       = (state_q == SEND);
   assign at_fin        = (idx_q == fin);
   assign s_axis_tready = ~rst & (~valid_q | (m_axis_tready & at_fin));
   assign accept        = s_axis_tvalid & s_axis_tready;

   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q & at_fin;
   assign m_axis_tdata  = M_DWIDTH'(data_q >> (idx_q * M_DWIDTH));
   assign m_axis_tkeep  = M_KEEP'(keep_q >> (idx_q * M_KEEP));

   // Holding register and slice index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
      end
   end

   // Retire or advance on an output handshake; a load overrides the retire.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      idx_d   = idx_q;
      case (state_q)
         SEND: begin
            if (m_axis_tready) begin
               if (at_fin) state_d = EMPTY;
               else        idx_d   = adv_idx;
            end
         end
         default: state_d = state_q;
      endcase
      if (accept) begin
         data_d  = s_axis_tdata;
         keep_d  = s_axis_tkeep;
         last_d  = s_axis_tlast;
         idx_d   = load_idx;
         state_d = load_valid ? SEND : EMPTY;
      end
   end

endmodule

// File: tb/tb_rifl_axis_downsizer.sv
// Directed self-checking bench for rifl_axis_downsizer at 256 -> 64 bits.
module tb_rifl_axis_downsizer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] s_axis_tdata = '0;
   logic [31:0]  s_axis_tkeep = '0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic [63:0]  m_axis_tdata;
   logic [7:0]   m_axis_tkeep;
   logic         m_axis_tlast;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [74:0] obs, req;
   logic [1:0]  obs_idle;

   logic [63:0] ea [0:3] = '{64'hA0A0_0101_0202_0303, 64'hA1A1_1111_1212_1313,
                             64'hA2A2_2121_2222_2323, 64'hA3A3_3131_3232_3333};
   logic [63:0] eb [0:3] = '{64'hB0B0_0404_0505_0606, 64'hB1B1_1414_1515_1616,
                             64'hB2B2_2424_2525_2626, 64'hB3B3_3434_3535_3636};
   logic [255:0] wa, wb;

   always #5 clk = ~clk;

   assign obs      = {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
   assign obs_idle = {s_axis_tready, m_axis_tvalid};

   rifl_axis_downsizer #(.S_DWIDTH(256), .M_DWIDTH(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      req = '0;
      n_cmp++;
      if (obs !== req) begin
         n_bad++;
         $display("FAIL reset_high: got %h required %h", obs, req);
      end
      rst = 1'b0;
      #1;
      req = {1'b1, 74'h0};
      n_cmp++;
      if (obs !== req) begin
         n_bad++;
         $display("FAIL reset_release: got %h required %h", obs, req);
      end
   endtask

   task automatic test_full_word();
      s_axis_tvalid = 1'b1; s_axis_tdata = wa; s_axis_tkeep = 32'hFFFF_FFFF;
      s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL full_word_idle: got %b required 10", obs_idle);
      end
      step();
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         req = {(k == 3), 1'b1, 1'b0, 8'hFF, ea[k]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL full_word beat %0d: got %h required %h", k, obs, req);
         end
         step();
      end
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL full_word_done: got %b required 10", obs_idle);
      end
   endtask

   task automatic test_truncated_last();
      s_axis_tvalid = 1'b1; s_axis_tdata = wb; s_axis_tkeep = 32'h0000_FFFF;
      s_axis_tlast = 1'b1; m_axis_tready = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         req = {(k == 1), 1'b1, (k == 1), 8'hFF, eb[k]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL truncated_last beat %0d: got %h required %h", k, obs, req);
         end
         step();
      end
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL truncated_last_done: got %b required 10", obs_idle);
      end
   endtask

   task automatic test_back_to_back();
      s_axis_tvalid = 1'b1; s_axis_tdata = wa; s_axis_tkeep = 32'hFFFF_FFFF;
      s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      step();
      s_axis_tdata = wb; s_axis_tlast = 1'b1;
      for (int b = 0; b < 8; b++) begin
         #1;
         req = {(b % 4 == 3), 1'b1, (b == 7), 8'hFF, (b < 4) ? ea[b] : eb[b - 4]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL back_to_back beat %0d: got %h required %h", b, obs, req);
         end
         step();
         if (b == 3) s_axis_tvalid = 1'b0;
      end
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL back_to_back_done: got %b required 10", obs_idle);
      end
   endtask

   task automatic test_backpressure();
      logic rdy [0:6];
      int   bt  [0:6];
      rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bt  = '{0, 1, 1, 2, 2, 3, 3};
      s_axis_tvalid = 1'b1; s_axis_tdata = wb; s_axis_tkeep = 32'hFFFF_FFFF;
      s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      for (int c = 0; c < 7; c++) begin
         m_axis_tready = rdy[c];
         #1;
         req = {(rdy[c] && bt[c] == 3), 1'b1, 1'b0, 8'hFF, eb[bt[c]]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL backpressure cycle %0d: got %h required %h", c, obs, req);
         end
         step();
      end
      m_axis_tready = 1'b1;
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL backpressure_done: got %b required 10", obs_idle);
      end
   endtask

   task automatic test_null_slices();
      s_axis_tvalid = 1'b1; s_axis_tdata = wa; s_axis_tkeep = 32'h00FF_00FF;
      s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
`ifdef RIFL_DWC_SKIP_NULL_EN
      for (int k = 0; k < 2; k++) begin
         #1;
         req = {(k == 1), 1'b1, 1'b0, 8'hFF, ea[2 * k]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL null_skip beat %0d: got %h required %h", k, obs, req);
         end
         step();
      end
      // an empty non-last word is swallowed
      s_axis_tvalid = 1'b1; s_axis_tkeep = 32'h0;
      step();
      s_axis_tvalid = 1'b0;
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL null_skip_empty_word: got %b required 10", obs_idle);
      end
`else
      for (int k = 0; k < 4; k++) begin
         #1;
         req = {(k == 3), 1'b1, 1'b0, (k % 2 == 0) ? 8'hFF : 8'h00, ea[k]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL null_keep beat %0d: got %h required %h", k, obs, req);
         end
         step();
      end
`endif
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL null_slices_done: got %b required 10", obs_idle);
      end
   endtask

   task automatic test_zero_keep_last();
      s_axis_tvalid = 1'b1; s_axis_tdata = wb; s_axis_tkeep = 32'h0;
      s_axis_tlast = 1'b1; m_axis_tready = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      #1;
      req = {1'b1, 1'b1, 1'b1, 8'h00, eb[0]};
      n_cmp++;
      if (obs !== req) begin
         n_bad++;
         $display("FAIL zero_keep_last: got %h required %h", obs, req);
      end
      step();
      #1;
      n_cmp++;
      if (obs_idle !== 2'b10) begin
         n_bad++;
         $display("FAIL zero_keep_last_done: got %b required 10", obs_idle);
      end
   endtask

   task automatic test_reset_mid_word();
      s_axis_tvalid = 1'b1; s_axis_tdata = wa; s_axis_tkeep = 32'hFFFF_FFFF;
      s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         req = {1'b0, 1'b1, 1'b0, 8'hFF, ea[k]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL mid_word beat %0d: got %h required %h", k, obs, req);
         end
         step();
      end
      rst = 1'b1;
      step();
      #1;
      req = '0;
      n_cmp++;
      if (obs !== req) begin
         n_bad++;
         $display("FAIL mid_word_in_reset: got %h required %h", obs, req);
      end
      rst = 1'b0;
      #1;
      req = {1'b1, 74'h0};
      n_cmp++;
      if (obs !== req) begin
         n_bad++;
         $display("FAIL mid_word_after_reset: got %h required %h", obs, req);
      end
      s_axis_tvalid = 1'b1; s_axis_tdata = wb;
      step();
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         req = {(k == 3), 1'b1, 1'b0, 8'hFF, eb[k]};
         n_cmp++;
         if (obs !== req) begin
            n_bad++;
            $display("FAIL mid_word_next beat %0d: got %h required %h", k, obs, req);
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      wa = {ea[3], ea[2], ea[1], ea[0]};
      wb = {eb[3], eb[2], eb[1], eb[0]};
      test_reset();
      test_full_word();
      test_truncated_last();
      test_back_to_back();
      test_backpressure();
      test_null_slices();
      test_zero_keep_last();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
